capture_snaplen: RTL and testbench

CAPTURE_SNAPLEN -- requirements
Module: capture_snaplen

---
 rtl/capture_snaplen_pkg.sv | 28 ++
 rtl/capture_snaplen_strb_mask_gen.sv | 19 +
 rtl/capture_snaplen.sv | 151 +++++++++++++++
 tb/tb_capture_snaplen.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_snaplen_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// capture_snaplen_pkg : shared capture constants, FSM encodings, helpers
// rev 1.0
// ---------------------------------------------------------------------------
package capture_snaplen_pkg;

  localparam int unsigned c_len_lsb     = 0;
  localparam int unsigned c_len_msb     = 15;
  localparam int unsigned c_beat_bytes  = 32;
  localparam int unsigned c_cnt_width   = 16;
  localparam int unsigned c_state_width = 2;

  typedef logic [c_state_width-1:0] state_t;

  localparam state_t c_st_first = 2'd0;
  localparam state_t c_st_pass  = 2'd1;
  localparam state_t c_st_drop  = 2'd2;

  // Advance the packet byte counter by one beat, sticking at all-ones.
  function automatic logic [c_cnt_width-1:0] cnt_add_beat(input logic [c_cnt_width-1:0] cnt);
    logic [c_cnt_width:0] sum;
    sum = {1'b0, cnt} + (c_cnt_width+1)'(c_beat_bytes);
    return sum[c_cnt_width] ? '1 : sum[c_cnt_width-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/capture_snaplen_strb_mask_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// strb_mask_gen : byte count -> low-bytes strobe mask (saturates at full width)
// rev 1.0
// ---------------------------------------------------------------------------
module strb_mask_gen #(
  parameter int STRB_WIDTH = 32,
  parameter int CNT_WIDTH  = 17
) (
  input  logic [CNT_WIDTH-1:0]  byte_cnt,
  output logic [STRB_WIDTH-1:0] mask
);

  for (genvar i = 0; i < STRB_WIDTH; i++) begin : g_mask_bit
    assign mask[i] = (32'(byte_cnt) > i);
  end

endmodule
`default_nettype wire

// File: rtl/capture_snaplen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// capture_snaplen : truncates captured packets to snaplen bytes, one-beat register
// rev 1.0
// ---------------------------------------------------------------------------
module capture_snaplen
  import capture_snaplen_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                              axi_aclk,
  input  logic                              axi_aresetn,
  input  logic [15:0]                       snaplen,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [31:0]                       trunc_count,
  output logic [31:0]                       pkt_count
);

  localparam int c_strb_width = C_M_AXIS_DATA_WIDTH / 8;

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic [c_cnt_width-1:0]            r_byte_cnt;
  logic [15:0]                       r_snaplen;
  logic [C_M_AXIS_DATA_WIDTH-1:0]    r_m_tdata;
  logic [c_strb_width-1:0]           r_m_tstrb;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   r_m_tuser;
  logic                              r_m_tvalid;
  logic                              r_m_tlast;
  logic [31:0]                       r_trunc_count;
  logic [31:0]                       r_pkt_count;

  logic                              w_accept;
  logic                              w_out_load;
  logic                              w_first;
  logic [15:0]                       w_snap;
  logic [c_cnt_width-1:0]            w_cnt;
  logic [c_cnt_width:0]              w_cnt_plus;
  logic [c_cnt_width:0]              w_remain;
  logic                              w_cut;
  logic [c_strb_width-1:0]           w_cut_mask;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   w_user;

  // Counter and snaplen are taken live on the first beat so the latch is transparent there.
  assign w_first    = (r_state == c_st_first);
  assign w_snap     = w_first ? snaplen : r_snaplen;
  assign w_cnt      = w_first ? '0 : r_byte_cnt;
  assign w_cnt_plus = {1'b0, w_cnt} + (c_cnt_width+1)'(c_beat_bytes);
  assign w_cut      = (w_snap != 16'd0) && (w_cnt_plus >= {1'b0, w_snap});
  assign w_remain   = {1'b0, w_snap} - {1'b0, w_cnt};

  strb_mask_gen #(
    .STRB_WIDTH (c_strb_width),
    .CNT_WIDTH  (c_cnt_width + 1)
  ) u_strb_mask (
    .byte_cnt (w_remain),
    .mask     (w_cut_mask)
  );

  always_comb begin
    w_user = s_axis_tuser;
    if (w_first && (w_snap != 16'd0) && (s_axis_tuser[c_len_msb:c_len_lsb] > w_snap))
      w_user[c_len_msb:c_len_lsb] = w_snap;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) r_state <= c_st_first;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      case (r_state)
        c_st_first, c_st_pass: begin
          if (s_axis_tlast)  w_state_nxt = c_st_first;
          else if (w_cut)    w_state_nxt = c_st_drop;
          else               w_state_nxt = c_st_pass;
        end
        c_st_drop: if (s_axis_tlast) w_state_nxt = c_st_first;
        default:   w_state_nxt = c_st_first;
      endcase
    end
  end

  always_comb begin
    s_axis_tready = 1'b0;
    if (axi_aresetn) begin
      case (r_state)
        c_st_drop: s_axis_tready = 1'b1;
        default:   s_axis_tready = !r_m_tvalid || m_axis_tready;
      endcase
    end
    w_accept   = s_axis_tvalid && s_axis_tready;
    w_out_load = w_accept && (r_state != c_st_drop);
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_byte_cnt    <= '0;
      r_snaplen     <= '0;
      r_m_tdata     <= '0;
      r_m_tstrb     <= '0;
      r_m_tuser     <= '0;
      r_m_tvalid    <= 1'b0;
      r_m_tlast     <= 1'b0;
      r_trunc_count <= '0;
      r_pkt_count   <= '0;
    end else begin
      if (w_accept) begin
        r_byte_cnt <= cnt_add_beat(w_cnt);
        if (w_first) r_snaplen <= snaplen;
      end
      if (w_out_load) begin
        r_m_tdata  <= s_axis_tdata;
        r_m_tstrb  <= w_cut ? (s_axis_tstrb & w_cut_mask) : s_axis_tstrb;
        r_m_tuser  <= w_user;
        r_m_tlast  <= s_axis_tlast || w_cut;
        r_m_tvalid <= 1'b1;
        if (w_cut && !s_axis_tlast) r_trunc_count <= r_trunc_count + 32'd1;
      end else if (m_axis_tready) begin
        r_m_tvalid <= 1'b0;
      end
      if (r_m_tvalid && m_axis_tready && r_m_tlast) r_pkt_count <= r_pkt_count + 32'd1;
    end
  end

  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tstrb  = r_m_tstrb;
  assign m_axis_tuser  = r_m_tuser;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign trunc_count   = r_trunc_count;
  assign pkt_count     = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_capture_snaplen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_capture_snaplen : table vectors, corner sequences and randomized packets
// rev 1.0
// ---------------------------------------------------------------------------
module tb_capture_snaplen;

  localparam int DW = 256;
  localparam int SW = 32;
  localparam int UW = 128;

  logic          axi_aclk = 1'b0;
  logic          axi_aresetn = 1'b1;
  logic [15:0]   snaplen = '0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [SW-1:0] s_axis_tstrb = '0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tstrb;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic [31:0]   trunc_count;
  logic [31:0]   pkt_count;

  always #5 axi_aclk = ~axi_aclk;

  capture_snaplen dut (
    .axi_aclk      (axi_aclk),
    .axi_aresetn   (axi_aresetn),
    .snaplen       (snaplen),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .trunc_count   (trunc_count),
    .pkt_count     (pkt_count)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct {
    int          snap;
    int          len;
    int          beats;
    logic [31:0] last_strb;
    int          out_len;
    int          trunc;
  } vec_t;

  beat_t cur_pkt[$];
  beat_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    exp_trunc = 0;
  int    exp_pkt = 0;
  bit    mon_en = 1'b1;
  int    sink_mode = 0;
  int    out_beats = 0;
  bit    mon_sop = 1'b1;
  logic [SW-1:0] last_strb = '0;
  logic [15:0]   first_len = '0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lowmask(input int k);
    if (k >= 32) return '1;
    return 32'((64'd1 << k) - 64'd1);
  endfunction

  // Sink: drives m_axis_tready and checks every accepted output beat.
  always begin
    beat_t e;
    @(negedge axi_aclk);
    case (sink_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = !m_axis_tready;
      default: m_axis_tready = ($urandom_range(0, 2) != 0);
    endcase
    #1;
    if (mon_en && axi_aresetn && m_axis_tvalid && m_axis_tready) begin
      out_beats++;
      if (mon_sop) first_len = m_axis_tuser[15:0];
      mon_sop   = m_axis_tlast;
      last_strb = m_axis_tstrb;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got tdata=%0h with nothing expected", m_axis_tdata);
      end else begin
        e = exp_q.pop_front();
        chk("beat_tdata", 512'(m_axis_tdata), 512'(e.data));
        chk("beat_tstrb", 512'(m_axis_tstrb), 512'(e.strb));
        chk("beat_tuser", 512'(m_axis_tuser), 512'(e.user));
        chk("beat_tlast", 512'(m_axis_tlast), 512'(e.last));
      end
    end
  end

  // Reference: output = beats up to the one where snaplen is reached.
  function automatic void model_pkt(input int snap, input int len);
    int n;
    int cut_idx;
    int n_out;
    beat_t b;
    n       = cur_pkt.size();
    cut_idx = (snap == 0) ? n : (snap + 31) / 32 - 1;
    n_out   = (cut_idx < n) ? cut_idx + 1 : n;
    for (int i = 0; i < n_out; i++) begin
      b = cur_pkt[i];
      if (i == 0 && snap != 0 && len > snap) b.user[15:0] = 16'(snap);
      if (i == cut_idx) begin
        b.strb = b.strb & lowmask(snap - 32 * i);
        b.last = 1'b1;
      end
      exp_q.push_back(b);
    end
    if (cut_idx < n - 1) exp_trunc++;
    exp_pkt++;
  endfunction

  task automatic send_pkt(input int len, input int snap, input int snap_late, input bit gaps);
    int n;
    logic [UW-1:0] user;
    beat_t b;
    int guard;
    bit done;
    n = (len + 31) / 32;
    for (int w = 0; w < UW / 32; w++) user[w*32 +: 32] = $urandom;
    user[15:0] = 16'(len);
    cur_pkt.delete();
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
      b.strb = lowmask((i == n - 1) ? len - 32 * i : 32);
      b.user = user;
      b.last = (i == n - 1);
      cur_pkt.push_back(b);
    end
    model_pkt(snap, len);
    for (int i = 0; i < n; i++) begin
      guard = 0;
      done  = 1'b0;
      while (!done) begin
        @(negedge axi_aclk);
        if (i == 0) snaplen = 16'(snap);
        if (i == 1 && snap_late >= 0) snaplen = 16'(snap_late);
        s_axis_tvalid = !gaps || ($urandom_range(0, 3) != 0);
        s_axis_tdata  = cur_pkt[i].data;
        s_axis_tstrb  = cur_pkt[i].strb;
        s_axis_tuser  = cur_pkt[i].user;
        s_axis_tlast  = cur_pkt[i].last;
        #2;
        if (s_axis_tvalid && s_axis_tready) done = 1'b1;
        else if (++guard > 2000) begin
          tests++;
          fails++;
          $display("FAIL input_stall: s_axis_tready held low for %0d cycles, required accept", guard);
          $display("[TB] %0d tests run, %0d failed", tests, fails);
          $fatal(1, "input stalled");
        end
      end
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    @(negedge axi_aclk);
    s_axis_tvalid = 1'b0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && guard < 500) begin
      @(negedge axi_aclk);
      guard++;
    end
    if (guard >= 500) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d beats still expected, required 0", exp_q.size());
      exp_q.delete();
    end
    #2;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_trunc_count"}, 512'(trunc_count), 512'(exp_trunc));
    chk({tag, "_pkt_count"}, 512'(pkt_count), 512'(exp_pkt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   tb_trunc;
    logic [DW-1:0] d;

    vecs[0] = '{snap: 0,   len: 80,  beats: 3, last_strb: 32'h0000FFFF, out_len: 80,  trunc: 0};
    vecs[1] = '{snap: 40,  len: 128, beats: 2, last_strb: 32'h000000FF, out_len: 40,  trunc: 1};
    vecs[2] = '{snap: 64,  len: 64,  beats: 2, last_strb: 32'hFFFFFFFF, out_len: 64,  trunc: 0};
    vecs[3] = '{snap: 33,  len: 100, beats: 2, last_strb: 32'h00000001, out_len: 33,  trunc: 1};
    vecs[4] = '{snap: 200, len: 100, beats: 4, last_strb: 32'h0000000F, out_len: 100, trunc: 0};
    vecs[5] = '{snap: 20,  len: 10,  beats: 1, last_strb: 32'h000003FF, out_len: 10,  trunc: 0};
    vecs[6] = '{snap: 32,  len: 96,  beats: 1, last_strb: 32'hFFFFFFFF, out_len: 32,  trunc: 1};
    vecs[7] = '{snap: 1,   len: 64,  beats: 1, last_strb: 32'h00000001, out_len: 1,   trunc: 1};

    // Reset state
    #2 axi_aresetn = 1'b0;
    repeat (3) @(negedge axi_aclk);
    #1;
    chk("reset_s_tready", 512'(s_axis_tready), 512'(0));
    chk("reset_m_tvalid", 512'(m_axis_tvalid), 512'(0));
    chk("reset_m_tdata", 512'(m_axis_tdata), 512'(0));
    chk("reset_counts", 512'({trunc_count, pkt_count}), 512'(0));
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;

    // Table vectors, tready held high
    tb_trunc = 0;
    for (int v = 0; v < 8; v++) begin
      out_beats = 0;
      send_pkt(vecs[v].len, vecs[v].snap, -1, 1'b0);
      drain();
      tb_trunc += vecs[v].trunc;
      chk($sformatf("vec%0d_beats", v), 512'(out_beats), 512'(vecs[v].beats));
      chk($sformatf("vec%0d_last_strb", v), 512'(last_strb), 512'(vecs[v].last_strb));
      chk($sformatf("vec%0d_len", v), 512'(first_len), 512'(vecs[v].out_len));
      chk($sformatf("vec%0d_trunc_count", v), 512'(trunc_count), 512'(tb_trunc));
      chk($sformatf("vec%0d_pkt_count", v), 512'(pkt_count), 512'(v + 1));
    end

    // Back-to-back truncated packets with tready toggling
    sink_mode = 1;
    out_beats = 0;
    send_pkt(128, 40, -1, 1'b0);
    send_pkt(128, 40, -1, 1'b0);
    drain();
    chk("b2b_beats", 512'(out_beats), 512'(4));
    chk_counters("b2b");

    // snaplen raised after the first beat has no effect on the packet
    sink_mode = 0;
    out_beats = 0;
    send_pkt(128, 40, 200, 1'b0);
    drain();
    chk("late_snap_beats", 512'(out_beats), 512'(2));
    chk("late_snap_len", 512'(first_len), 512'(40));
    chk("late_snap_strb", 512'(last_strb), 512'(32'h000000FF));

    // Randomized packets against the reference model
    sink_mode = 2;
    for (int p = 0; p < 60; p++) begin
      int len;
      int snap;
      int late;
      len = $urandom_range(1, 300);
      case ($urandom_range(0, 3))
        0:       snap = 0;
        1:       snap = $urandom_range(1, 400);
        2:       snap = 32 * $urandom_range(1, 8);
        default: snap = len;
      endcase
      late = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 400) : -1;
      send_pkt(len, snap, late, 1'b1);
    end
    drain();
    chk_counters("random");

    // Reset while dropping the tail of a truncated packet
    sink_mode = 0;
    mon_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge axi_aclk);
      snaplen = 16'd40;
      for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
      s_axis_tdata  = d;
      s_axis_tstrb  = '1;
      s_axis_tuser  = UW'(128);
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b1;
    end
    @(negedge axi_aclk);
    s_axis_tvalid = 1'b0;
    #1;
    chk("drop_trunc_count", 512'(trunc_count), 512'(exp_trunc + 1));
    chk("drop_s_tready", 512'(s_axis_tready), 512'(1));
    #2 axi_aresetn = 1'b0;
    #1;
    chk("rst_m_tvalid", 512'(m_axis_tvalid), 512'(0));
    chk("rst_m_tlast", 512'(m_axis_tlast), 512'(0));
    chk("rst_m_payload", 512'({m_axis_tdata, m_axis_tstrb, m_axis_tuser}), 512'(0));
    chk("rst_counts", 512'({trunc_count, pkt_count}), 512'(0));
    chk("rst_s_tready", 512'(s_axis_tready), 512'(0));
    exp_q.delete();
    exp_trunc = 0;
    exp_pkt   = 0;
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    mon_sop = 1'b1;
    mon_en  = 1'b1;
    out_beats = 0;
    send_pkt(64, 0, -1, 1'b0);
    drain();
    chk("post_rst_pkt_count", 512'(pkt_count), 512'(1));
    chk("post_rst_trunc_count", 512'(trunc_count), 512'(0));
    chk("post_rst_beats", 512'(out_beats), 512'(2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
